// File: rtl/compl_angle.sv
// Rectangular-to-polar converter: iterative vectoring-mode CORDIC returning
// the phase (4096 units per turn) and gain-corrected magnitude of (r, i).
module compl_angle #(
    parameter int unsigned W    = 16,
    parameter int unsigned AW   = 12,
    parameter int unsigned ITER = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  r,
    input  logic [W-1:0]  i,
    output logic          out_valid,
    output logic [AW-1:0] angle,
    output logic [W-1:0]  mag
);

    localparam int unsigned XW      = W + 2;
    localparam int unsigned ZW      = AW + 4;
    localparam int unsigned KW      = $clog2(ITER + 1);
    localparam int unsigned PW      = XW + 15;
    localparam int unsigned GAIN    = 19898;
    localparam int unsigned MAG_MAX = (2 ** W) - 1;

    typedef enum logic [1:0] {IDLE, ROT, FIN} state_t;

    state_t               state_q, state_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic [ZW-1:0]        z_q, z_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 zero_q, zero_d;
    logic [AW-1:0]        angle_q, angle_d;
    logic [W-1:0]         mag_q, mag_d;
    logic                 out_valid_q, out_valid_d;

    logic signed [XW-1:0] r_ext, i_ext, xsh, ysh;
    logic [XW-1:0]        x_mag;
    logic [ZW-1:0]        z_rnd;
    logic [PW-1:0]        prod, prod_sh;

    // atan(2^-k) in units of 1/16 LSB of the angle (65536 per turn)
    function automatic logic [ZW-1:0] atan_lut(input logic [KW-1:0] k);
        case (k)
            KW'(0):  atan_lut = ZW'(8192);
            KW'(1):  atan_lut = ZW'(4836);
            KW'(2):  atan_lut = ZW'(2555);
            KW'(3):  atan_lut = ZW'(1297);
            KW'(4):  atan_lut = ZW'(651);
            KW'(5):  atan_lut = ZW'(326);
            KW'(6):  atan_lut = ZW'(163);
            KW'(7):  atan_lut = ZW'(81);
            KW'(8):  atan_lut = ZW'(41);
            KW'(9):  atan_lut = ZW'(20);
            KW'(10): atan_lut = ZW'(10);
            KW'(11): atan_lut = ZW'(5);
            default: atan_lut = '0;
        endcase
    endfunction

    // Next-state, datapath and output logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        k_d         = k_q;
        zero_d      = zero_q;
        angle_d     = angle_q;
        mag_d       = mag_q;
        out_valid_d = 1'b0;

        r_ext   = XW'($signed(r));
        i_ext   = XW'($signed(i));
        xsh     = x_q >>> k_q;
        ysh     = y_q >>> k_q;
        z_rnd   = z_q + ZW'(8);
        x_mag   = x_q[XW-1] ? '0 : $unsigned(x_q);
        prod    = PW'(x_mag) * PW'(GAIN);
        prod_sh = prod >> 15;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Fold the left half-plane onto the right, pre-loading 180 degrees
                    if (r[W-1]) begin
                        x_d = -r_ext;
                        y_d = -i_ext;
                        z_d = ZW'(1) << (ZW - 1);
                    end else begin
                        x_d = r_ext;
                        y_d = i_ext;
                        z_d = '0;
                    end
                    zero_d  = (r == '0) && (i == '0);
                    k_d     = '0;
                    state_d = ROT;
                end
            end
            ROT: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + ysh;
                    y_d = y_q - xsh;
                    z_d = z_q + atan_lut(k_q);
                end else begin
                    x_d = x_q - ysh;
                    y_d = y_q + xsh;
                    z_d = z_q - atan_lut(k_q);
                end
                k_d = k_q + KW'(1);
                if (k_q == KW'(ITER - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                angle_d = AW'(z_rnd >> 4);
                mag_d   = (prod_sh > PW'(MAG_MAX)) ? '1 : W'(prod_sh);
                if (zero_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            k_q         <= '0;
            zero_q      <= 1'b0;
            angle_q     <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            k_q         <= k_d;
            zero_q      <= zero_d;
            angle_q     <= angle_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign angle     = angle_q;
    assign mag       = mag_q;

endmodule

// File: tb/tb_compl_angle.sv
// Directed and randomized checks for the compl_angle CORDIC converter.
module tb_compl_angle;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] r_in;
    logic signed [15:0] i_in;
    logic               out_valid;
    logic [11:0]        angle;
    logic [15:0]        mag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compl_angle #(.W(16), .AW(12), .ITER(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .r        (r_in),
        .i        (i_in),
        .out_valid(out_valid),
        .angle    (angle),
        .mag      (mag)
    );

    // Circular distance between two angle codes
    function automatic int adist(input int a, input int b);
        int d;
        d = (((a - b) % 4096) + 4096) % 4096;
        return (d > 2048) ? 4096 - d : d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Single transfer; lat = edges from the accept edge until out_valid is seen
    task automatic run_one(input int rv, input int iv, output int a, output int m, output int lat);
        @(negedge clk);
        r_in = 16'(rv); i_in = 16'(iv); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        a = int'(angle);
        m = int'(mag);
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; in_valid = 1'b0; r_in = '0; i_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle !== 12'd0 || mag !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_rst rdy=%b ov=%b angle=%0d mag=%0d exp 1 0 0 0", in_ready, out_valid, angle, mag);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle !== 12'd0 || mag !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d rdy=%b ov=%b angle=%0d mag=%0d exp 1 0 0 0", c, in_ready, out_valid, angle, mag);
            end
        end
        // reset together with in_valid must not accept anything
        rst = 1'b1; in_valid = 1'b1; r_in = 16'sd16384; i_in = 16'sd0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_vs_valid_ready got=%b exp=1", in_ready);
        end
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_vs_valid_pulses got=%0d exp=0", seen);
        end
    endtask

    task automatic test_axes();
        int rv[4] = '{16384, 0, -16384, 0};
        int iv[4] = '{0, 16384, 0, -16384};
        int ea[4] = '{0, 1024, 2048, 3072};
        int a, m, lat;
        for (int n = 0; n < 4; n++) begin
            run_one(rv[n], iv[n], a, m, lat);
            checks++;
            if (lat != 13) begin
                errors++;
                $display("FAIL axis_latency n=%0d got=%0d exp=13", n, lat);
            end
            checks++;
            if (a != ea[n]) begin
                errors++;
                $display("FAIL axis_angle n=%0d got=%0d exp=%0d", n, a, ea[n]);
            end
            checks++;
            if (iabs(m - 16384) > 4) begin
                errors++;
                $display("FAIL axis_mag n=%0d got=%0d exp=16384+-4", n, m);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || int'(angle) != a) begin
                errors++;
                $display("FAIL axis_pulse n=%0d ov=%b rdy=%b angle=%0d exp ov=0 rdy=1 angle=%0d", n, out_valid, in_ready, angle, a);
            end
        end
    endtask

    task automatic test_diagonals();
        int rv[3] = '{11585, -11585, 16384};
        int iv[3] = '{11585, -11585, -1};
        int ea[3] = '{512, 2560, 0};
        int a, m, lat;
        for (int n = 0; n < 3; n++) begin
            run_one(rv[n], iv[n], a, m, lat);
            checks++;
            if (lat != 13 || adist(a, ea[n]) > 1) begin
                errors++;
                $display("FAIL diag_angle n=%0d got=%0d lat=%0d exp=%0d+-1 lat=13", n, a, lat, ea[n]);
            end
            checks++;
            if (iabs(m - 16384) > 4) begin
                errors++;
                $display("FAIL diag_mag n=%0d got=%0d exp=16384+-4", n, m);
            end
        end
        checks++;
        if (a != 0 && a != 4095) begin
            errors++;
            $display("FAIL diag_wrap got=%0d exp=0_or_4095", a);
        end
    endtask

    task automatic test_extremes();
        int a, m, lat;
        run_one(0, 0, a, m, lat);
        checks++;
        if (lat != 13 || a != 0 || m != 0) begin
            errors++;
            $display("FAIL zero_input angle=%0d mag=%0d lat=%0d exp 0 0 13", a, m, lat);
        end
        run_one(-32768, 0, a, m, lat);
        checks++;
        if (adist(a, 2048) > 1) begin
            errors++;
            $display("FAIL neg_full_angle got=%0d exp=2048+-1", a);
        end
        checks++;
        if (iabs(m - 32768) > 4) begin
            errors++;
            $display("FAIL neg_full_mag got=%0d exp=32768+-4", m);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int wait_c;
        @(negedge clk);
        r_in = 16'sd0; i_in = 16'sd16384; in_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (in_ready === 1'b1) acc.push_back(c);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=4", acc.size());
        end
        for (int n = 1; n < acc.size(); n++) begin
            checks++;
            if (acc[n] - acc[n-1] != 14) begin
                errors++;
                $display("FAIL b2b_spacing n=%0d got=%0d exp=14", n, acc[n] - acc[n-1]);
            end
        end
        wait_c = 0;
        while (in_ready !== 1'b1 && wait_c < 30) begin
            @(negedge clk);
            wait_c++;
        end
        checks++;
        if (in_ready !== 1'b1 || int'(angle) != 1024) begin
            errors++;
            $display("FAIL b2b_drain rdy=%b angle=%0d exp rdy=1 angle=1024", in_ready, angle);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, seen;
        @(negedge clk);
        r_in = 16'sd16384; i_in = 16'sd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            lat++;
            r_in = 16'sd0; i_in = 16'sd16384; in_valid = (c % 2 == 1);
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 13 || angle !== 12'd0) begin
            errors++;
            $display("FAIL busy_ignore angle=%0d lat=%0d exp angle=0 lat=13", angle, lat);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL busy_extra_result got=%0d exp=0", seen);
        end
    endtask

    task automatic test_reset_abort();
        int a, m, lat, seen;
        run_one(0, -16384, a, m, lat);
        checks++;
        if (a != 3072) begin
            errors++;
            $display("FAIL abort_setup_angle got=%0d exp=3072", a);
        end
        @(negedge clk);
        r_in = 16'sd11585; i_in = 16'sd11585; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || angle !== 12'd0 || mag !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state ov=%b angle=%0d mag=%0d rdy=%b exp 0 0 0 1", out_valid, angle, mag, in_ready);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_pulses got=%0d exp=0", seen);
        end
        run_one(0, 16384, a, m, lat);
        checks++;
        if (lat != 13 || a != 1024) begin
            errors++;
            $display("FAIL abort_recover angle=%0d lat=%0d exp 1024 13", a, lat);
        end
    endtask

    task automatic test_random();
        int rv, iv, a, m, lat, ea;
        real ra, rm, md;
        for (int n = 0; n < 1000; n++) begin
            do begin
                rv = int'($urandom_range(32768, 0)) - 16384;
                iv = int'($urandom_range(32768, 0)) - 16384;
            end while (rv * rv + iv * iv < 4096 * 4096);
            run_one(rv, iv, a, m, lat);
            ra = $atan2(real'(iv), real'(rv)) * 4096.0 / (2.0 * 3.14159265358979);
            if (ra < 0.0) ra = ra + 4096.0;
            ea = int'($floor(ra + 0.5)) % 4096;
            rm = $sqrt(real'(rv) * real'(rv) + real'(iv) * real'(iv));
            checks++;
            if (lat != 13 || adist(a, ea) > 1) begin
                errors++;
                $display("FAIL rand_angle r=%0d i=%0d got=%0d lat=%0d exp=%0d+-1", rv, iv, a, lat, ea);
            end
            md = real'(m) - rm;
            if (md < 0.0) md = -md;
            checks++;
            if (md > 4.0) begin
                errors++;
                $display("FAIL rand_mag r=%0d i=%0d got=%0d exp=%0.2f+-4", rv, iv, m, rm);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; r_in = '0; i_in = '0;
        test_reset();
        test_axes();
        test_diagonals();
        test_extremes();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
